// File: rtl/parking_pkg.sv
// Shared constants for the parking bay timer and the fee stage downstream.
package parking_pkg;

    // Width of the elapsed-seconds count handed to the fee stage.
    localparam int unsigned CNT_W = 21;

    // Seconds per fee step; the fee stage divides the frozen count by this.
    localparam int unsigned FEE_STEP = 600;

    // Saturation value of the elapsed count.
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Bay state encoding; 2'd3 is unused and falls back to IDLE.
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] PARKED = 2'd1;
    localparam logic [1:0] BILL   = 2'd2;

endpackage

// File: rtl/parking_timer_if.sv
// Bay-side signal bundle: sensors and payment in, frozen stay count and status out.
interface parking_timer_if;
    import parking_pkg::*;

    logic             car_in;
    logic             car_out;
    logic             pay_ack;
    logic [CNT_W-1:0] counterp;
    logic             busy;
    logic             bill_valid;

    // Bay controller / test driver side.
    modport master (
        output car_in,
        output car_out,
        output pay_ack,
        input  counterp,
        input  busy,
        input  bill_valid
    );

    // Timer side.
    modport slave (
        input  car_in,
        input  car_out,
        input  pay_ack,
        output counterp,
        output busy,
        output bill_valid
    );

endinterface

// File: rtl/tick_gen.sv
// One-second prescaler: pulses tick for one cycle every TICK_DIV enabled cycles.
module tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q;

    assign tick = en && (pre_q == PRE_LAST);

    // Count while enabled, wrap after the last cycle of a second; clr restarts a full second.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q <= '0;
        end else if (clr) begin
            pre_q <= '0;
        end else if (en) begin
            pre_q <= tick ? '0 : pre_q + 1'b1;
        end
    end

endmodule

// File: rtl/parking_timer.sv
// Per-bay stay timer: counts seconds from entry to exit and holds the result for billing.
module parking_timer import parking_pkg::*; #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic           clk,
    input  logic           rst,
    parking_timer_if.slave bus
);

    logic [2:0]       in_sync_q;
    logic [2:0]       out_sync_q;
    logic             in_ev;
    logic             out_ev;
    logic             tick;
    logic             park_start;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] counterp_q;
    logic [CNT_W-1:0] counterp_d;

    // Two synchronizer flops plus one history flop per raw sensor.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_sync_q  <= '0;
            out_sync_q <= '0;
        end else begin
            in_sync_q  <= {in_sync_q[1:0], bus.car_in};
            out_sync_q <= {out_sync_q[1:0], bus.car_out};
        end
    end

    // A held level yields a single event on its rising edge.
    assign in_ev  = in_sync_q[1] & ~in_sync_q[2];
    assign out_ev = out_sync_q[1] & ~out_sync_q[2];

    assign park_start = (state_q == IDLE) && in_ev;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == PARKED),
        .clr  (park_start),
        .tick (tick)
    );

    // Next state and count; a tick in the exit cycle is still counted.
    always_comb begin
        state_d    = state_q;
        counterp_d = counterp_q;
        case (state_q)
            IDLE: begin
                if (in_ev) begin
                    state_d    = PARKED;
                    counterp_d = '0;
                end
            end
            PARKED: begin
                if (tick && (counterp_q != CNT_MAX)) begin
                    counterp_d = counterp_q + 1'b1;
                end
                if (out_ev) begin
                    state_d = BILL;
                end
            end
            BILL: begin
                if (bus.pay_ack) begin
                    state_d    = IDLE;
                    counterp_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                counterp_d = '0;
            end
        endcase
    end

    // State and count registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            counterp_q <= '0;
        end else begin
            state_q    <= state_d;
            counterp_q <= counterp_d;
        end
    end

    assign bus.counterp   = counterp_q;
    assign bus.busy       = (state_q == PARKED) || (state_q == BILL);
    assign bus.bill_valid = (state_q == BILL);

endmodule
